vend_payment_ctrl: RTL and testbench

VEND_PAYMENT_CTRL -- requirements
Module: vend_payment_ctrl

---
 rtl/vend_payment_ctrl_if.sv | 53 +++++
 rtl/vend_payment_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_vend_payment_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vend_payment_ctrl_if.sv
// Handshake bundle between the vending front panel, the drink sequencer and the
// payment controller. The slave side is the controller; the master side is the panel/sequencer.
interface vend_payment_ctrl_if;
    logic       coin_100;
    logic       coin_500;
    logic       sel_valid;
    logic [7:0] price;
    logic       cancel;
    logic       dispense_done;

    logic       pay_ok;
    logic       need_more;
    logic       coin_reject;
    logic       ret_100;
    logic       ret_500;
    logic [7:0] credit;
    logic       busy;
    logic [1:0] state;

    modport master (
        output coin_100,
        output coin_500,
        output sel_valid,
        output price,
        output cancel,
        output dispense_done,
        input  pay_ok,
        input  need_more,
        input  coin_reject,
        input  ret_100,
        input  ret_500,
        input  credit,
        input  busy,
        input  state
    );

    modport slave (
        input  coin_100,
        input  coin_500,
        input  sel_valid,
        input  price,
        input  cancel,
        input  dispense_done,
        output pay_ok,
        output need_more,
        output coin_reject,
        output ret_100,
        output ret_500,
        output credit,
        output busy,
        output state
    );
endinterface

// File: rtl/vend_payment_ctrl.sv
// Coin acceptance, drink payment and paced change payout for a vending machine.
// Every output is a flop; inputs sampled at edge n are reflected on outputs after edge n.
module vend_payment_ctrl #(
    parameter int unsigned MAX_CREDIT = 15,
    parameter int unsigned PULSE_GAP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    vend_payment_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COLLECT   = 2'd1,
        ST_WAIT_DISP = 2'd2,
        ST_PAYOUT    = 2'd3
    } state_t;

    localparam int              GAP_W      = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(PULSE_GAP - 1);
    localparam logic [8:0]      MAX_CREDIT9 = 9'(MAX_CREDIT);

    state_t           state_q, state_d;
    logic [7:0]       credit_q, credit_d;
    logic [7:0]       payout_q, payout_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic [7:0]       credit_out_q, credit_out_d;
    logic             busy_q, busy_d;
    logic             pay_ok_q, pay_ok_d;
    logic             need_more_q, need_more_d;
    logic             coin_reject_q, coin_reject_d;
    logic             ret_100_q, ret_100_d;
    logic             ret_500_q, ret_500_d;

    logic             any_coin;
    logic [7:0]       coin_credit;
    logic             coin_rej;
    logic [8:0]       sum_500;
    logic [8:0]       sum_100;
    logic [7:0]       after_500;

    assign any_coin = bus.coin_100 | bus.coin_500;

    // The 500 coin is tried first; the 100 coin is then tried against the updated credit.
    always_comb begin
        sum_500     = {1'b0, credit_q} + 9'd5;
        after_500   = credit_q;
        coin_rej    = 1'b0;
        if (bus.coin_500) begin
            if (sum_500 <= MAX_CREDIT9) begin
                after_500 = sum_500[7:0];
            end else begin
                coin_rej = 1'b1;
            end
        end
        sum_100     = {1'b0, after_500} + 9'd1;
        coin_credit = after_500;
        if (bus.coin_100) begin
            if (sum_100 <= MAX_CREDIT9) begin
                coin_credit = sum_100[7:0];
            end else begin
                coin_rej = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        payout_d      = payout_q;
        gap_d         = gap_q;
        pay_ok_d      = 1'b0;
        need_more_d   = 1'b0;
        coin_reject_d = 1'b0;
        ret_100_d     = 1'b0;
        ret_500_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                need_more_d   = bus.sel_valid;
                coin_reject_d = coin_rej;
                if (coin_credit != 8'd0) begin
                    credit_d = coin_credit;
                    state_d  = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (bus.cancel) begin
                    coin_reject_d = any_coin;
                    payout_d      = credit_q;
                    credit_d      = 8'd0;
                    gap_d         = '0;
                    state_d       = (credit_q != 8'd0) ? ST_PAYOUT : ST_IDLE;
                end else if (bus.sel_valid) begin
                    coin_reject_d = any_coin;
                    if ((bus.price != 8'd0) && (bus.price <= credit_q)) begin
                        pay_ok_d = 1'b1;
                        payout_d = credit_q - bus.price;
                        credit_d = 8'd0;
                        state_d  = ST_WAIT_DISP;
                    end else begin
                        need_more_d = 1'b1;
                    end
                end else begin
                    credit_d      = coin_credit;
                    coin_reject_d = coin_rej;
                end
            end

            ST_WAIT_DISP: begin
                coin_reject_d = any_coin;
                if (bus.dispense_done) begin
                    gap_d   = '0;
                    state_d = (payout_q != 8'd0) ? ST_PAYOUT : ST_IDLE;
                end
            end

            ST_PAYOUT: begin
                coin_reject_d = any_coin;
                if (payout_q == 8'd0) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else if (gap_q == '0) begin
                    if (payout_q >= 8'd5) begin
                        ret_500_d = 1'b1;
                        payout_d  = payout_q - 8'd5;
                    end else begin
                        ret_100_d = 1'b1;
                        payout_d  = payout_q - 8'd1;
                    end
                    gap_d = GAP_RELOAD;
                    if (payout_d == 8'd0) begin
                        gap_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The visible credit follows the state being entered so it lines up with state/busy.
        unique case (state_d)
            ST_COLLECT: credit_out_d = credit_d;
            ST_PAYOUT:  credit_out_d = payout_d;
            default:    credit_out_d = 8'd0;
        endcase
        busy_d = (state_d == ST_WAIT_DISP) || (state_d == ST_PAYOUT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= 8'd0;
            payout_q      <= 8'd0;
            gap_q         <= '0;
            credit_out_q  <= 8'd0;
            busy_q        <= 1'b0;
            pay_ok_q      <= 1'b0;
            need_more_q   <= 1'b0;
            coin_reject_q <= 1'b0;
            ret_100_q     <= 1'b0;
            ret_500_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            payout_q      <= payout_d;
            gap_q         <= gap_d;
            credit_out_q  <= credit_out_d;
            busy_q        <= busy_d;
            pay_ok_q      <= pay_ok_d;
            need_more_q   <= need_more_d;
            coin_reject_q <= coin_reject_d;
            ret_100_q     <= ret_100_d;
            ret_500_q     <= ret_500_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.credit      = credit_out_q;
    assign bus.busy        = busy_q;
    assign bus.pay_ok      = pay_ok_q;
    assign bus.need_more   = need_more_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.ret_100     = ret_100_q;
    assign bus.ret_500     = ret_500_q;

endmodule

// File: tb/tb_vend_payment_ctrl.sv
// Directed scoreboard bench: each step queues the outputs expected after its clock edge,
// and a monitor pops and compares them just after that edge.
module tb_vend_payment_ctrl;

    logic clk;
    logic rst;

    vend_payment_ctrl_if if_a ();
    vend_payment_ctrl_if if_b ();

    vend_payment_ctrl #(.MAX_CREDIT(15), .PULSE_GAP(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    vend_payment_ctrl #(.MAX_CREDIT(5), .PULSE_GAP(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pulse field order: busy, pay_ok, need_more, coin_reject, ret_100, ret_500
    localparam logic [5:0] P_NONE = 6'b000000;
    localparam logic [5:0] P_BUSY = 6'b100000;
    localparam logic [5:0] P_PAY  = 6'b010000;
    localparam logic [5:0] P_NEED = 6'b001000;
    localparam logic [5:0] P_REJ  = 6'b000100;
    localparam logic [5:0] P_R1   = 6'b000010;
    localparam logic [5:0] P_R5   = 6'b000001;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COLL = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_PAY  = 2'd3;

    typedef struct {
        string       tag;
        bit          dut;
        logic [15:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int checks = 0;
    int errors = 0;

    logic [15:0] obs_a;
    logic [15:0] obs_b;
    assign obs_a = {if_a.state, if_a.credit, if_a.busy, if_a.pay_ok, if_a.need_more,
                    if_a.coin_reject, if_a.ret_100, if_a.ret_500};
    assign obs_b = {if_b.state, if_b.credit, if_b.busy, if_b.pay_ok, if_b.need_more,
                    if_b.coin_reject, if_b.ret_100, if_b.ret_500};

    always @(posedge clk) begin
        sb_entry_t   e;
        logic [15:0] obs;
        #1;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = e.dut ? obs_b : obs_a;
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
            $display("check %0d dut%0d %s observed=%h expected=%h", checks, e.dut, e.tag, obs, e.exp);
        end
    end

    task automatic drive_zero();
        if_a.coin_100 = 0; if_a.coin_500 = 0; if_a.sel_valid = 0; if_a.price = 8'd0;
        if_a.cancel = 0; if_a.dispense_done = 0;
        if_b.coin_100 = 0; if_b.coin_500 = 0; if_b.sel_valid = 0; if_b.price = 8'd0;
        if_b.cancel = 0; if_b.dispense_done = 0;
    endtask

    task automatic step(input string tag, input bit dut, input logic rn,
                        input logic c1, input logic c5, input logic sel, input logic [7:0] pr,
                        input logic can, input logic dn,
                        input logic [1:0] st, input logic [7:0] cr, input logic [5:0] pl);
        sb_entry_t e;
        @(negedge clk);
        drive_zero();
        rst = rn;
        if (dut) begin
            if_b.coin_100 = c1; if_b.coin_500 = c5; if_b.sel_valid = sel; if_b.price = pr;
            if_b.cancel = can; if_b.dispense_done = dn;
        end else begin
            if_a.coin_100 = c1; if_a.coin_500 = c5; if_a.sel_valid = sel; if_a.price = pr;
            if_a.cancel = can; if_a.dispense_done = dn;
        end
        e.tag = tag;
        e.dut = dut;
        e.exp = {st, cr, pl};
        sb_q.push_back(e);
    endtask

    task automatic nop(input string tag, input bit dut, input int n,
                       input logic [1:0] st, input logic [7:0] cr, input logic [5:0] pl);
        for (int i = 0; i < n; i++) step(tag, dut, 1, 0, 0, 0, 8'd0, 0, 0, st, cr, pl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive_zero();

        // reset, inputs ignored while reset low
        step("reset",          0, 0, 0, 0, 0, 8'd0, 0, 0, S_IDLE, 8'd0, P_NONE);
        step("reset_ign_coin", 0, 0, 1, 1, 0, 8'd0, 0, 0, S_IDLE, 8'd0, P_NONE);
        step("reset_ign_b",    1, 0, 1, 1, 0, 8'd0, 0, 0, S_IDLE, 8'd0, P_NONE);

        // idle: selection refused, cancel ignored
        step("idle_sel",    0, 1, 0, 0, 1, 8'd3, 0, 0, S_IDLE, 8'd0, P_NEED);
        step("idle_cancel", 0, 1, 0, 0, 0, 8'd0, 1, 0, S_IDLE, 8'd0, P_NONE);

        // purchase with 2 change
        step("buy_c500",  0, 1, 0, 1, 0, 8'd0, 0, 0, S_COLL, 8'd5, P_NONE);
        step("buy_c100",  0, 1, 1, 0, 0, 8'd0, 0, 0, S_COLL, 8'd6, P_NONE);
        step("buy_sel4",  0, 1, 0, 0, 1, 8'd4, 0, 0, S_WAIT, 8'd0, P_BUSY | P_PAY);
        nop ("buy_wait",  0, 1, S_WAIT, 8'd0, P_BUSY);
        step("buy_done",  0, 1, 0, 0, 0, 8'd0, 0, 1, S_PAY, 8'd2, P_BUSY);
        nop ("buy_ret0",  0, 1, S_PAY, 8'd1, P_BUSY | P_R1);
        nop ("buy_gap",   0, 3, S_PAY, 8'd1, P_BUSY);
        nop ("buy_ret4",  0, 1, S_IDLE, 8'd0, P_R1);
        nop ("buy_idle",  0, 1, S_IDLE, 8'd0, P_NONE);

        // short credit, zero price, then refund of 3
        step("ref_c1",    0, 1, 1, 0, 0, 8'd0, 0, 0, S_COLL, 8'd1, P_NONE);
        step("ref_c2",    0, 1, 1, 0, 0, 8'd0, 0, 0, S_COLL, 8'd2, P_NONE);
        step("ref_c3",    0, 1, 1, 0, 0, 8'd0, 0, 0, S_COLL, 8'd3, P_NONE);
        step("ref_sel5",  0, 1, 0, 0, 1, 8'd5, 0, 0, S_COLL, 8'd3, P_NEED);
        step("ref_sel0",  0, 1, 0, 0, 1, 8'd0, 0, 0, S_COLL, 8'd3, P_NEED);
        step("ref_cancel",0, 1, 0, 0, 0, 8'd0, 1, 0, S_PAY, 8'd3, P_BUSY);
        nop ("ref_ret0",  0, 1, S_PAY, 8'd2, P_BUSY | P_R1);
        nop ("ref_gap1",  0, 3, S_PAY, 8'd2, P_BUSY);
        nop ("ref_ret1",  0, 1, S_PAY, 8'd1, P_BUSY | P_R1);
        nop ("ref_gap2",  0, 3, S_PAY, 8'd1, P_BUSY);
        nop ("ref_ret2",  0, 1, S_IDLE, 8'd0, P_R1);
        nop ("ref_idle",  0, 1, S_IDLE, 8'd0, P_NONE);

        // credit ceiling at 15
        step("max_c5a",   0, 1, 0, 1, 0, 8'd0, 0, 0, S_COLL, 8'd5, P_NONE);
        step("max_c5b",   0, 1, 0, 1, 0, 8'd0, 0, 0, S_COLL, 8'd10, P_NONE);
        step("max_c11",   0, 1, 1, 0, 0, 8'd0, 0, 0, S_COLL, 8'd11, P_NONE);
        step("max_c12",   0, 1, 1, 0, 0, 8'd0, 0, 0, S_COLL, 8'd12, P_NONE);
        step("max_c13",   0, 1, 1, 0, 0, 8'd0, 0, 0, S_COLL, 8'd13, P_NONE);
        step("max_c14",   0, 1, 1, 0, 0, 8'd0, 0, 0, S_COLL, 8'd14, P_NONE);
        step("max_rej500",0, 1, 0, 1, 0, 8'd0, 0, 0, S_COLL, 8'd14, P_REJ);
        step("max_c15",   0, 1, 1, 0, 0, 8'd0, 0, 0, S_COLL, 8'd15, P_NONE);
        step("max_rej100",0, 1, 1, 0, 0, 8'd0, 0, 0, S_COLL, 8'd15, P_REJ);
        step("max_sel16", 0, 1, 0, 0, 1, 8'd16, 0, 0, S_COLL, 8'd15, P_NEED);
        step("max_sel15", 0, 1, 0, 0, 1, 8'd15, 0, 0, S_WAIT, 8'd0, P_BUSY | P_PAY);
        step("max_done",  0, 1, 0, 0, 0, 8'd0, 0, 1, S_IDLE, 8'd0, P_NONE);

        // exact price, coin during dispense, no change
        step("ex_c5",     0, 1, 0, 1, 0, 8'd0, 0, 0, S_COLL, 8'd5, P_NONE);
        step("ex_c6",     0, 1, 1, 0, 0, 8'd0, 0, 0, S_COLL, 8'd6, P_NONE);
        step("ex_c7",     0, 1, 1, 0, 0, 8'd0, 0, 0, S_COLL, 8'd7, P_NONE);
        step("ex_sel7",   0, 1, 0, 0, 1, 8'd7, 0, 0, S_WAIT, 8'd0, P_BUSY | P_PAY);
        step("ex_wcoin",  0, 1, 1, 0, 1, 8'd2, 1, 0, S_WAIT, 8'd0, P_BUSY | P_REJ);
        step("ex_done",   0, 1, 0, 0, 0, 8'd0, 0, 1, S_IDLE, 8'd0, P_NONE);
        nop ("ex_idle",   0, 2, S_IDLE, 8'd0, P_NONE);

        // cancel beats selection in the same cycle
        step("cs_c1",     0, 1, 1, 0, 0, 8'd0, 0, 0, S_COLL, 8'd1, P_NONE);
        step("cs_both",   0, 1, 0, 0, 1, 8'd1, 1, 0, S_PAY, 8'd1, P_BUSY);
        nop ("cs_ret",    0, 1, S_IDLE, 8'd0, P_R1);

        // reset in the middle of a payout of 6
        step("rp_c5",     0, 1, 0, 1, 0, 8'd0, 0, 0, S_COLL, 8'd5, P_NONE);
        step("rp_c6",     0, 1, 1, 0, 0, 8'd0, 0, 0, S_COLL, 8'd6, P_NONE);
        step("rp_cancel", 0, 1, 0, 0, 0, 8'd0, 1, 0, S_PAY, 8'd6, P_BUSY);
        nop ("rp_ret500", 0, 1, S_PAY, 8'd1, P_BUSY | P_R5);
        nop ("rp_gap",    0, 1, S_PAY, 8'd1, P_BUSY);
        step("rp_rst",    0, 0, 0, 0, 0, 8'd0, 0, 0, S_IDLE, 8'd0, P_NONE);
        nop ("rp_after",  0, 6, S_IDLE, 8'd0, P_NONE);

        // MAX_CREDIT = 5: both coins together from idle
        step("m5_both",   1, 1, 1, 1, 0, 8'd0, 0, 0, S_COLL, 8'd5, P_REJ);
        step("m5_both2",  1, 1, 1, 1, 0, 8'd0, 0, 0, S_COLL, 8'd5, P_REJ);
        step("m5_cancel", 1, 1, 0, 0, 0, 8'd0, 1, 0, S_PAY, 8'd5, P_BUSY);
        nop ("m5_ret500", 1, 1, S_IDLE, 8'd0, P_R5);
        nop ("m5_idle",   1, 1, S_IDLE, 8'd0, P_NONE);

        @(negedge clk);
        drive_zero();
        repeat (2) @(negedge clk);
        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
